// File: rtl/cv32e40p_tb_exit_pkg.sv
// Shared types for the end-of-test monitor: FSM states, per-channel report status, exit code width.
package cv32e40p_tb_exit_pkg;

    localparam int EXIT_CODE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } exit_state_e;

    typedef enum logic [1:0] {
        PENDING,
        PASSED,
        FAILED
    } ch_status_e;

endpackage

// File: rtl/cv32e40p_tb_exit_channel.sv
// Sticky capture of one channel's first pass/fail report; status is registered, the
// decoded fail code is combinational so the top can latch the first failure on the same edge.
module cv32e40p_tb_exit_channel
    import cv32e40p_tb_exit_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sample_i,
    input  logic                   passed_i,
    input  logic                   failed_i,
    input  logic                   exit_valid_i,
    input  logic [EXIT_CODE_W-1:0] exit_value_i,
    output logic                   fin_o,
    output logic                   fail_o,
    output logic                   fin_d_o,
    output logic                   fail_d_o,
    output logic                   fail_now_o,
    output logic [EXIT_CODE_W-1:0] code_now_o
);

    ch_status_e status_q, status_d;
    logic       report;
    logic       is_fail;
    logic       capture;

    always_comb begin
        report     = passed_i | failed_i | exit_valid_i;
        // A fail indication wins over a simultaneous pass on the same channel.
        is_fail    = failed_i | (exit_valid_i && (exit_value_i != '0));
        capture    = sample_i && (status_q == PENDING) && report;
        status_d   = status_q;
        if (capture) begin
            status_d = is_fail ? FAILED : PASSED;
        end
        code_now_o = failed_i ? EXIT_CODE_W'(1) : exit_value_i;
        fail_now_o = capture && is_fail;
        fin_d_o    = (status_d != PENDING);
        fail_d_o   = (status_d == FAILED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= PENDING;
        end else begin
            status_q <= status_d;
        end
    end

    assign fin_o  = (status_q != PENDING);
    assign fail_o = (status_q == FAILED);

endmodule

// File: rtl/cv32e40p_tb_exit_monitor.sv
// End-of-test monitor: collects channel reports, runs a watchdog and drain window, emits a sticky verdict.
// done_o/pass_o rise DRAIN_CYCLES+1 cycles after the edge that samples the terminating event.
module cv32e40p_tb_exit_monitor
    import cv32e40p_tb_exit_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 16,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic [CNT_WIDTH-1:0]          max_cycles_i,
    input  logic [NUM_CH-1:0]             passed_i,
    input  logic [NUM_CH-1:0]             failed_i,
    input  logic [NUM_CH-1:0]             exit_valid_i,
    input  logic [NUM_CH*EXIT_CODE_W-1:0] exit_value_i,
    output logic                          done_o,
    output logic                          pass_o,
    output logic                          timeout_o,
    output logic [NUM_CH-1:0]             finished_o,
    output logic [NUM_CH-1:0]             fail_mask_o,
    output logic [4:0]                    fail_ch_o,
    output logic [EXIT_CODE_W-1:0]        fail_code_o,
    output logic [CNT_WIDTH-1:0]          cycle_cnt_o
);

    exit_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:0]            drain_q, drain_d;
    logic                   done_q, pass_q, timeout_q, timeout_d;
    logic                   fail_seen_q;
    logic [4:0]             fail_ch_q;
    logic [EXIT_CODE_W-1:0] fail_code_q;

    logic                   sample;
    logic                   cnt_inc;
    logic                   complete;
    logic                   wd_hit;
    logic [NUM_CH-1:0]      fin_q, fail_q, fin_d, fail_d, fail_now;
    logic [EXIT_CODE_W-1:0] code_now [NUM_CH];
    logic                   first_found;
    logic [4:0]             first_idx;
    logic [EXIT_CODE_W-1:0] first_code;

    assign sample = ((state_q == RUN) && enable_i) || (state_q == DRAIN);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        cv32e40p_tb_exit_channel u_ch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .sample_i     (sample),
            .passed_i     (passed_i[k]),
            .failed_i     (failed_i[k]),
            .exit_valid_i (exit_valid_i[k]),
            .exit_value_i (exit_value_i[k*EXIT_CODE_W +: EXIT_CODE_W]),
            .fin_o        (fin_q[k]),
            .fail_o       (fail_q[k]),
            .fin_d_o      (fin_d[k]),
            .fail_d_o     (fail_d[k]),
            .fail_now_o   (fail_now[k]),
            .code_now_o   (code_now[k])
        );
    end

    // Descending scan so the lowest failing index is the one left standing.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        first_code  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (fail_now[k]) begin
                first_found = 1'b1;
                first_idx   = 5'(k);
                first_code  = code_now[k];
            end
        end
    end

    assign complete = (&fin_d) || (STOP_ON_FAIL && (|fail_d));
    assign wd_hit   = (max_cycles_i != '0) && (cnt_q >= max_cycles_i);

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        timeout_d = timeout_q;
        cnt_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                drain_d = '0;
                if (enable_i) begin
                    // Completion is checked first so it wins over a same-cycle watchdog hit.
                    if (complete) begin
                        state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                    end else if (wd_hit) begin
                        state_d   = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                cnt_inc = 1'b1;
                drain_d = drain_q + 32'd1;
                if (drain_q == 32'(DRAIN_CYCLES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
        cnt_d = cnt_q;
        if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            drain_q     <= '0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            fail_ch_q   <= '0;
            fail_code_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            timeout_q <= timeout_d;
            if (first_found && !fail_seen_q) begin
                fail_seen_q <= 1'b1;
                fail_ch_q   <= first_idx;
                fail_code_q <= first_code;
            end
            if ((state_q == DONE) && !done_q) begin
                done_q <= 1'b1;
                pass_q <= (fail_q == '0) && !timeout_q && (&fin_q);
            end
        end
    end

    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign finished_o  = fin_q;
    assign fail_mask_o = fail_q;
    assign fail_ch_o   = fail_ch_q;
    assign fail_code_o = fail_code_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_cv32e40p_tb_exit_monitor.sv
// Scoreboard bench: two monitor instances (stop-on-fail with 16-cycle drain, and wait-all with no drain).
module tb_cv32e40p_tb_exit_monitor;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic [31:0] max_cycles_i;
    logic [1:0]  passed_i, failed_i, exit_valid_i;
    logic [63:0] exit_value_i;

    logic        done_a, pass_a, to_a, done_b, pass_b, to_b;
    logic [1:0]  fin_a, mask_a, fin_b, mask_b;
    logic [4:0]  ch_a, ch_b;
    logic [31:0] code_a, cnt_a, code_b, cnt_b;

    always #5 clk_i = ~clk_i;

    cv32e40p_tb_exit_monitor #(.NUM_CH(2), .CNT_WIDTH(32), .DRAIN_CYCLES(16), .STOP_ON_FAIL(1'b1)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .max_cycles_i(max_cycles_i),
        .passed_i(passed_i), .failed_i(failed_i), .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
        .done_o(done_a), .pass_o(pass_a), .timeout_o(to_a), .finished_o(fin_a), .fail_mask_o(mask_a),
        .fail_ch_o(ch_a), .fail_code_o(code_a), .cycle_cnt_o(cnt_a)
    );

    cv32e40p_tb_exit_monitor #(.NUM_CH(2), .CNT_WIDTH(32), .DRAIN_CYCLES(0), .STOP_ON_FAIL(1'b0)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .max_cycles_i(max_cycles_i),
        .passed_i(passed_i), .failed_i(failed_i), .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
        .done_o(done_b), .pass_o(pass_b), .timeout_o(to_b), .finished_o(fin_b), .fail_mask_o(mask_b),
        .fail_ch_o(ch_b), .fail_code_o(code_b), .cycle_cnt_o(cnt_b)
    );

    typedef struct {
        int          dut;
        int          done_edge;
        logic        pass;
        logic        to;
        logic [1:0]  fin;
        logic [1:0]  mask;
        logic [4:0]  ch;
        logic [31:0] code;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edges   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        edges++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_inputs();
        passed_i     = '0;
        failed_i     = '0;
        exit_valid_i = '0;
        exit_value_i = '0;
    endtask

    task automatic start(input logic [31:0] maxc);
        rst_ni       = 1'b0;
        enable_i     = 1'b0;
        max_cycles_i = maxc;
        clear_inputs();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        enable_i = 1'b1;
        tick();
        edges = 0;
    endtask

    task automatic pulse(input logic [1:0] p, input logic [1:0] f, input logic [1:0] v, input logic [63:0] val);
        passed_i     = p;
        failed_i     = f;
        exit_valid_i = v;
        exit_value_i = val;
        tick();
        clear_inputs();
    endtask

    task automatic push(input int dut, input int de, input logic pass, input logic to, input logic [1:0] fin,
                        input logic [1:0] mask, input logic [4:0] ch, input logic [31:0] code, input logic [31:0] cnt);
        exp_t e;
        e.dut = dut; e.done_edge = de; e.pass = pass; e.to = to; e.fin = fin;
        e.mask = mask; e.ch = ch; e.code = code; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        while ((((e.dut == 0) ? done_a : done_b) == 1'b0) && (edges < e.done_edge + 50)) tick();
        if (e.dut == 0) begin
            check({tag, ".done"},  64'(done_a), 64'd1);
            check({tag, ".edge"},  64'(edges),  64'(e.done_edge));
            check({tag, ".pass"},  64'(pass_a), 64'(e.pass));
            check({tag, ".to"},    64'(to_a),   64'(e.to));
            check({tag, ".fin"},   64'(fin_a),  64'(e.fin));
            check({tag, ".mask"},  64'(mask_a), 64'(e.mask));
            check({tag, ".ch"},    64'(ch_a),   64'(e.ch));
            check({tag, ".code"},  64'(code_a), 64'(e.code));
            check({tag, ".cnt"},   64'(cnt_a),  64'(e.cnt));
        end else begin
            check({tag, ".done"},  64'(done_b), 64'd1);
            check({tag, ".edge"},  64'(edges),  64'(e.done_edge));
            check({tag, ".pass"},  64'(pass_b), 64'(e.pass));
            check({tag, ".to"},    64'(to_b),   64'(e.to));
            check({tag, ".fin"},   64'(fin_b),  64'(e.fin));
            check({tag, ".mask"},  64'(mask_b), 64'(e.mask));
            check({tag, ".ch"},    64'(ch_b),   64'(e.ch));
            check({tag, ".code"},  64'(code_b), 64'(e.code));
            check({tag, ".cnt"},   64'(cnt_b),  64'(e.cnt));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        rst_ni       = 1'b0;
        enable_i     = 1'b0;
        max_cycles_i = '0;
        clear_inputs();
        tick();
        check("rst.done", 64'(done_a), 64'd0);
        check("rst.pass", 64'(pass_a), 64'd0);
        check("rst.to",   64'(to_a),   64'd0);
        check("rst.fin",  64'(fin_a),  64'd0);
        check("rst.mask", 64'(mask_a), 64'd0);
        check("rst.ch",   64'(ch_a),   64'd0);
        check("rst.code", 64'(code_a), 64'd0);
        check("rst.cnt",  64'(cnt_a),  64'd0);

        // Both channels pass; terminating report lands on edge 20 with 19 counted RUN cycles.
        start(32'd0);
        idle(9);
        pulse(2'b01, 2'b00, 2'b00, 64'd0);
        idle(9);
        pulse(2'b00, 2'b00, 2'b10, 64'd0);
        push(1, edges + 1,  1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 32'd0, 32'd19);
        push(0, edges + 17, 1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 32'd0, 32'd35);
        check_done("s1b");
        check_done("s1a");
        pulse(2'b00, 2'b01, 2'b00, 64'd0);
        idle(2);
        check("s1a.absorb_mask", 64'(mask_a), 64'd0);
        check("s1a.absorb_cnt",  64'(cnt_a),  64'd35);

        // Channel 1 fails with code 0x2A, channel 0 silent.
        start(32'd0);
        idle(4);
        pulse(2'b00, 2'b00, 2'b10, 64'h0000002A_00000000);
        push(0, edges + 17, 1'b0, 1'b0, 2'b10, 2'b10, 5'd1, 32'h2A, 32'd20);
        check_done("s2a");

        // Watchdog at 100 with no reports.
        start(32'd100);
        push(1, 102, 1'b0, 1'b1, 2'b00, 2'b00, 5'd0, 32'd0, 32'd100);
        push(0, 118, 1'b0, 1'b1, 2'b00, 2'b00, 5'd0, 32'd0, 32'd116);
        check_done("s3b");
        check_done("s3a");

        // Last channel passes on the very edge the watchdog would fire.
        start(32'd100);
        idle(4);
        pulse(2'b01, 2'b00, 2'b00, 64'd0);
        idle(95);
        pulse(2'b10, 2'b00, 2'b00, 64'd0);
        push(1, edges + 1,  1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 32'd0, 32'd100);
        push(0, edges + 17, 1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 32'd0, 32'd116);
        check_done("s3cb");
        check_done("s3ca");

        // Same-cycle fails: ch0 via failed_i, ch1 via code 7 -> lowest index wins with code 1.
        start(32'd0);
        idle(2);
        pulse(2'b00, 2'b01, 2'b10, 64'h00000007_00000000);
        push(0, edges + 17, 1'b0, 1'b0, 2'b11, 2'b11, 5'd0, 32'd1, 32'd18);
        check_done("s4a");

        // Pass and fail together on one channel counts as a fail.
        start(32'd0);
        idle(3);
        pulse(2'b01, 2'b01, 2'b00, 64'd0);
        push(0, edges + 17, 1'b0, 1'b0, 2'b01, 2'b01, 5'd0, 32'd1, 32'd19);
        check_done("s4ba");

        // Wait-all mode, zero drain: ch0 passes, ch1 fails three cycles later.
        start(32'd0);
        idle(2);
        pulse(2'b01, 2'b00, 2'b00, 64'd0);
        idle(2);
        pulse(2'b00, 2'b00, 2'b10, 64'h00000055_00000000);
        push(1, edges + 1, 1'b0, 1'b0, 2'b11, 2'b10, 5'd1, 32'h55, 32'd5);
        check_done("s5b");

        // Asynchronous reset in the middle of a run.
        start(32'd0);
        idle(2);
        pulse(2'b01, 2'b00, 2'b00, 64'd0);
        idle(2);
        check("s6.pre_cnt", 64'(cnt_b), 64'd5);
        check("s6.pre_fin", 64'(fin_b), 64'd1);
        rst_ni = 1'b0;
        #2;
        check("s6.cnt_b",  64'(cnt_b),  64'd0);
        check("s6.fin_b",  64'(fin_b),  64'd0);
        check("s6.done_b", 64'(done_b), 64'd0);
        check("s6.cnt_a",  64'(cnt_a),  64'd0);
        check("s6.fin_a",  64'(fin_a),  64'd0);

        // Ten disabled cycles freeze the counter and push the watchdog out by ten.
        start(32'd30);
        idle(5);
        check("s7.cnt_before", 64'(cnt_a), 64'd5);
        enable_i = 1'b0;
        idle(10);
        check("s7.cnt_frozen", 64'(cnt_a),  64'd5);
        check("s7.not_done",   64'(done_a), 64'd0);
        check("s7.no_to",      64'(to_a),   64'd0);
        enable_i = 1'b1;
        push(1, 42, 1'b0, 1'b1, 2'b00, 2'b00, 5'd0, 32'd0, 32'd30);
        push(0, 58, 1'b0, 1'b1, 2'b00, 2'b00, 5'd0, 32'd0, 32'd46);
        check_done("s7b");
        check_done("s7a");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_tb_exit_monitor.md
# cv32e40p_tb_exit_monitor

Synthesizable end-of-test monitor for multi-core testbench subsystems. Collects pass/fail/exit reports from `NUM_CH` independent channels, runs a programmable cycle watchdog and a post-exit drain window, then reports a single sticky verdict. It replaces ad-hoc per-bench `$finish` logic and sits beside the subsystem wrappers at bench top level, so the verdict can also be used by emulation builds.

## Interface
- `NUM_CH`, 2: number of reporting channels (cores/subsystems), 1..32.
- `CNT_WIDTH`, 32: cycle counter and watchdog width.
- `DRAIN_CYCLES`, 16: cycles between verdict decision and `done_o`, so stdout can flush; 0 is legal.
- `STOP_ON_FAIL`, 1: 1 means the first failing channel ends the run; 0 means wait for all channels.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `enable_i`  in  1  counting/monitoring enable; low holds the block in IDLE.
- `max_cycles_i`  in  CNT_WIDTH  watchdog limit; 0 disables the watchdog.
- `passed_i`  in  NUM_CH  per-channel pass pulse.
- `failed_i`  in  NUM_CH  per-channel fail pulse.
- `exit_valid_i`  in  NUM_CH  per-channel exit-code strobe.
- `exit_value_i`  in  NUM_CH×32  packed exit codes; channel k is `[32k+31:32k]`.
- `done_o`  out  1  verdict final (sticky).
- `pass_o`  out  1  all channels passed, no timeout (valid when `done_o`).
- `timeout_o`  out  1  watchdog fired.
- `finished_o`  out  NUM_CH  channel has reported.
- `fail_mask_o`  out  NUM_CH  channel reported failure.
- `fail_ch_o`  out  5  index of first failing channel.
- `fail_code_o`  out  32  exit code of first failing channel (1 for `failed_i`).
- `cycle_cnt_o`  out  CNT_WIDTH  cycles spent in RUN + DRAIN.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE → RUN when `enable_i`=1. RUN/DRAIN return to IDLE only on reset; `enable_i` low in RUN freezes the counter and the state.
- Channel report: `passed_i[k]`, or `exit_valid_i[k]` with code 0, means pass. `failed_i[k]`, or `exit_valid_i[k]` with a nonzero code, means fail. The first report per channel is sticky; later reports are ignored. Pass and fail in the same cycle on one channel counts as fail.
- First-fail capture: on the earliest failing cycle, the lowest-index failing channel is captured into `fail_ch_o`/`fail_code_o`. These are never overwritten.
- RUN → DRAIN when every channel has finished, or when any channel fails and `STOP_ON_FAIL`=1.
- RUN → DRAIN with timeout when `max_cycles_i`≠0 and `cycle_cnt` ≥ `max_cycles_i`.
- Completion and timeout in the same cycle: completion wins and `timeout_o` stays 0.
- Reports arriving in DRAIN are still recorded in `finished_o`/`fail_mask_o`. They do not change the verdict, except that a fail in DRAIN with `STOP_ON_FAIL`=0 clears `pass_o`. The watchdog is ignored in DRAIN.
- DRAIN → DONE after `DRAIN_CYCLES` cycles. With `DRAIN_CYCLES`=0, DRAIN lasts 0 cycles: RUN → DONE directly.
- DONE is absorbing. All inputs are ignored and the counter holds.
- `pass_o` = no fail bits, no timeout, and all channels finished, evaluated at DONE entry.
- `cycle_cnt` increments in RUN (when enabled) and in DRAIN, and saturates at all-ones.

## Timing
- Reset values: `done_o`=0, `pass_o`=0, `timeout_o`=0, `finished_o`=0, `fail_mask_o`=0, `fail_ch_o`=0, `fail_code_o`=0, `cycle_cnt_o`=0.
- All inputs are sampled on rising `clk_i`. Status outputs are registered and update the cycle after the sampling edge.
- `done_o` rises exactly `DRAIN_CYCLES`+1 cycles after the edge that sampled the terminating event.
- Watchdog: with `max_cycles_i`=N, the timeout is sampled on the edge where `cycle_cnt`=N, i.e. after N enabled RUN cycles.
- Reset asserted mid-run clears everything asynchronously. Monitoring restarts from IDLE after deassertion.

## Structure
- Package `cv32e40p_tb_exit_pkg` holds:
  - the state enum `exit_state_e` (IDLE/RUN/DRAIN/DONE);
  - the channel status enum `ch_status_e` (PENDING/PASSED/FAILED);
  - the `EXIT_CODE_W`=32 constant.
- Sub-module `cv32e40p_tb_exit_channel`, instantiated `NUM_CH` times, does the per-channel sticky capture of status and code.
- The top level holds the FSM, watchdog counter, drain counter and lowest-index fail priority encoder.

## Test plan
- NUM_CH=2: ch0 `passed_i` at cycle 10, ch1 `exit_valid_i` code 0 at cycle 20 → DRAIN; `done_o` at cycle 20+16+1, `pass_o`=1, `finished_o`=2'b11.
- ch1 exit code 0x2A at cycle 5, `STOP_ON_FAIL`=1 → `fail_ch_o`=1, `fail_code_o`=0x2A, `pass_o`=0, `done_o` 17 cycles later; ch0 never reports.
- `max_cycles_i`=100, no reports → `timeout_o`=1 and `cycle_cnt_o` holds 100+16 at `done_o`, `pass_o`=0. Repeat with the last channel passing on the limit cycle → `timeout_o`=0, `pass_o`=1.
- Same-cycle fails on ch0 (`failed_i`) and ch1 (code 7) → `fail_ch_o`=0, `fail_code_o`=1. Also drive `passed_i`+`failed_i` together on one channel → counted as fail.
- `STOP_ON_FAIL`=0 with `DRAIN_CYCLES`=0: ch0 passes, ch1 fails 3 cycles later → `done_o` the next cycle, `fail_mask_o`=2'b10. Then assert `rst_ni`=0 mid-run → all outputs 0 immediately.
- Toggle `enable_i` low for 10 cycles in RUN → `cycle_cnt_o` frozen for those 10 cycles and the watchdog delayed by 10.
